// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide unit.
package muldiv_pkg;

  // Operation codes delivered by decode.
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  // Control states of the iterative engine.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } muldiv_state_t;

  // Fill bit for LO after a divide by zero (LO becomes all ones).
  localparam logic DIVZ_LO_FILL = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the datapath: radix-2 shift-add multiply or
// restoring shift-subtract divide on a 2*WIDTH accumulator.
// Multiply: acc = {partial product, remaining multiplier bits}.
// Divide:   acc = {partial remainder, dividend bits / quotient bits}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opb_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_part;
  logic [WIDTH:0]   div_diff;
  logic             div_nb;
  logic [WIDTH-1:0] div_rem;

  // Compute both step flavours and select the one requested by the mode.
  always_comb begin
    mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
             + ({1'b0, opb_i} & {(WIDTH+1){acc_i[0]}});
    div_part = acc_i[2*WIDTH-1:WIDTH-1];
    div_diff = div_part - {1'b0, opb_i};
    div_nb   = ~div_diff[WIDTH];
    if (div_nb) begin
      div_rem = div_diff[WIDTH-1:0];
    end else begin
      div_rem = div_part[WIDTH-1:0];
    end
    if (div_i) begin
      acc_o = {div_rem, acc_i[WIDTH-2:0], div_nb};
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Operates on magnitudes and applies the sign correction in FIX.
import muldiv_pkg::*;

module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn && x[WIDTH-1]) begin
      mag = -x;
    end else begin
      mag = x;
    end
  endfunction

  muldiv_state_t      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] step_acc;
  logic               op_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] fix_prod;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i (state_q == DIV),
    .acc_i (acc_q),
    .opb_i (opb_q),
    .acc_o (step_acc)
  );

  // Operand magnitudes for the request being presented.
  always_comb begin
    op_signed = (op == OP_MULT) || (op == OP_DIV);
    a_mag     = mag(rs_val, op_signed);
    b_mag     = mag(rt_val, op_signed);
  end

  // Sign-corrected result as it will be written into HI/LO.
  always_comb begin
    fix_prod = acc_q;
    if (is_div_q) begin
      if (neg_hi_q) begin
        fix_hi = -acc_q[2*WIDTH-1:WIDTH];
      end else begin
        fix_hi = acc_q[2*WIDTH-1:WIDTH];
      end
      if (neg_lo_q) begin
        fix_lo = -acc_q[WIDTH-1:0];
      end else begin
        fix_lo = acc_q[WIDTH-1:0];
      end
    end else begin
      if (neg_lo_q) begin
        fix_prod = -acc_q;
      end else begin
        fix_prod = acc_q;
      end
      fix_hi = fix_prod[2*WIDTH-1:WIDTH];
      fix_lo = fix_prod[WIDTH-1:0];
    end
  end

  // Next-state logic: request acceptance, iteration, write-back and flush.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi_d = rs_val;
              OP_MTLO: lo_d = rs_val;
              OP_MULT, OP_MULTU: begin
                acc_d    = {{WIDTH{1'b0}}, a_mag};
                opb_d    = b_mag;
                neg_lo_d = op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                neg_hi_d = op_signed && rs_val[WIDTH-1];
                is_div_d = 1'b0;
                cnt_d    = CNT_LOAD;
                state_d  = MUL;
              end
              OP_DIV, OP_DIVU: begin
                is_div_d = 1'b1;
                opb_d    = b_mag;
                state_d  = DIV;
                if (rt_val == {WIDTH{1'b0}}) begin
                  // Preset result: drains through one empty DIV cycle unchanged.
                  acc_d    = {rs_val, {WIDTH{DIVZ_LO_FILL}}};
                  neg_lo_d = 1'b0;
                  neg_hi_d = 1'b0;
                  cnt_d    = CNT_ZERO;
                end else begin
                  acc_d    = {{WIDTH{1'b0}}, a_mag};
                  neg_lo_d = op_signed && (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                  neg_hi_d = op_signed && rs_val[WIDTH-1];
                  cnt_d    = CNT_LOAD;
                end
              end
              default: state_d = IDLE;
            endcase
          end else begin
            state_d = IDLE;
          end
        end
        MUL, DIV: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = FIX;
          end else begin
            acc_d = step_acc;
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        FIX: begin
          hi_d    = fix_hi;
          lo_d    = fix_lo;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      acc_q    <= {(2*WIDTH){1'b0}};
      opb_q    <= {WIDTH{1'b0}};
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// Self-checking bench for muldiv_hilo: vector table, random ops against
// an arithmetic reference model, and hand-written abort/reset sequences.
import muldiv_pkg::*;

module tb_muldiv_hilo;

  logic        clk;
  logic        rst_n;
  logic        start;
  muldiv_op_t  op_r;
  logic [31:0] rs_r;
  logic [31:0] rt_r;
  logic        abort;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  muldiv_hilo #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op_r),
    .rs_val (rs_r),
    .rt_val (rt_r),
    .abort  (abort),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural reference: plain signed/unsigned 64-bit arithmetic.
  task automatic ref_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    rh = 32'h0;
    rl = 32'h0;
    case (o)
      OP_MULT: begin
        sp = sa * sb;
        rh = sp[63:32];
        rl = sp[31:0];
      end
      OP_MULTU: begin
        up = ua * ub;
        rh = up[63:32];
        rl = up[31:0];
      end
      OP_DIV: begin
        if (b == 32'h0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          sq = sa / sb;
          sr = sa % sb;
          rh = sr[31:0];
          rl = sq[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 32'h0) begin
          rh = a;
          rl = 32'hFFFF_FFFF;
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          rh = ur[31:0];
          rl = uq[31:0];
        end
      end
      default: begin
        rh = 32'h0;
        rl = 32'h0;
      end
    endcase
  endtask

  // Issue one compute op and wait (bounded) for done; reports latency
  // in edges after the accepting edge and whether busy stayed high.
  task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy_ok, output logic busy_at_done);
    @(negedge clk);
    start = 1'b1;
    op_r  = o;
    rs_r  = a;
    rt_r  = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk);
      #1;
      lat++;
    end
    busy_at_done = busy;
  endtask

  task automatic move_to(input muldiv_op_t o, input logic [31:0] v, input logic ab);
    @(negedge clk);
    start = 1'b1;
    op_r  = o;
    rs_r  = v;
    abort = ab;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int          lat;
    logic        bok;
    logic        bdone;
    logic [31:0] eh;
    logic [31:0] el;
    muldiv_op_t  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        seen;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    op_r  = OP_MULT;
    rs_r  = 32'h0;
    rt_r  = 32'h0;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 34};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 34};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[3] = '{OP_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFC, 34};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34};
    vecs[5] = '{OP_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 2};
    vecs[6] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[7] = '{OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", {32'h0, hi}, 64'h0);
    chk("reset_lo", {32'h0, lo}, 64'h0);
    chk("reset_busy", {63'h0, busy}, 64'h0);
    chk("reset_done", {63'h0, done}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bok, bdone);
      chk($sformatf("vec%0d_hi", i), {32'h0, hi}, {32'h0, vecs[i].hi});
      chk($sformatf("vec%0d_lo", i), {32'h0, lo}, {32'h0, vecs[i].lo});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
      chk($sformatf("vec%0d_busy", i), {62'h0, bok, bdone}, 64'h2);
    end

    // Randomised ops against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = muldiv_op_t'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'h0;
        1:       rb = $urandom_range(1, 9);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      ref_op(ro, ra, rb, eh, el);
      run_op(ro, ra, rb, lat, bok, bdone);
      chk($sformatf("rnd%0d_hi", i), {32'h0, hi}, {32'h0, eh});
      chk($sformatf("rnd%0d_lo", i), {32'h0, lo}, {32'h0, el});
      chk($sformatf("rnd%0d_lat", i), 64'(lat),
          ((ro == OP_DIV || ro == OP_DIVU) && rb == 32'h0) ? 64'd2 : 64'd34);
      mdl_hi = eh;
      mdl_lo = el;
    end

    // MTHI / MTLO preload, each visible one edge later.
    move_to(OP_MTHI, 32'h1234_5678, 1'b0);
    chk("mthi_hi", {32'h0, hi}, 64'h1234_5678);
    chk("mthi_lo_kept", {32'h0, lo}, {32'h0, mdl_lo});
    chk("mthi_busy", {62'h0, busy, done}, 64'h0);
    move_to(OP_MTLO, 32'h9ABC_DEF0, 1'b0);
    chk("mtlo_lo", {32'h0, lo}, 64'h9ABC_DEF0);
    chk("mtlo_hi_kept", {32'h0, hi}, 64'h1234_5678);
    mdl_hi = 32'h1234_5678;
    mdl_lo = 32'h9ABC_DEF0;

    // Abort together with MTHI, and an illegal op code: both ignored.
    move_to(OP_MTHI, 32'hDEAD_BEEF, 1'b1);
    chk("abort_mthi_hi", {32'h0, hi}, {32'h0, mdl_hi});
    move_to(muldiv_op_t'(3'd6), 32'h5555_5555, 1'b0);
    chk("illegal_busy", {63'h0, busy}, 64'h0);
    chk("illegal_hilo", {hi, lo}, {mdl_hi, mdl_lo});

    // MULT 3*4 with a start while busy at edge 5 and abort at edge 10.
    @(negedge clk);
    start = 1'b1;
    op_r  = OP_MULT;
    rs_r  = 32'd3;
    rt_r  = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    op_r  = OP_MTLO;
    rs_r  = 32'h1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_start_ignored", {63'h0, busy}, 64'h1);
    chk("busy_start_lo", {32'h0, lo}, {32'h0, mdl_lo});
    repeat (4) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_busy", {62'h0, busy, done}, 64'h0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen = 1'b1;
    end
    chk("abort_no_done", {63'h0, seen}, 64'h0);
    chk("abort_hilo", {hi, lo}, {mdl_hi, mdl_lo});

    // Abort landing on the write-back cycle suppresses the write.
    @(negedge clk);
    start = 1'b1;
    op_r  = OP_MULTU;
    rs_r  = 32'd7;
    rt_r  = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (33) @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("fix_abort_flags", {62'h0, busy, done}, 64'h0);
    chk("fix_abort_hilo", {hi, lo}, {mdl_hi, mdl_lo});

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1;
    op_r  = OP_DIV;
    rs_r  = 32'd1000;
    rt_r  = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_hilo", {hi, lo}, 64'h0);
    chk("async_rst_busy", {63'h0, busy}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bok, bdone);
    chk("post_rst_lo", {32'h0, lo}, 64'd14);
    chk("post_rst_hi", {32'h0, hi}, 64'd2);
    chk("post_rst_lat", 64'(lat), 64'd34);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
